// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds PS/2 Set-2 E0/F0/E1 prefixes into key events and buffers them in a FWFT FIFO
module ps2_scancode_decoder #(
  parameter int P_FIFO_DEPTH   = 16,
  parameter int P_FIFO_DEPTH_N = 4
) (
  input  logic                      iCLOCK,
  input  logic                      inRESET,
  input  logic                      iSCAN_REQ,
  input  logic [7:0]                iSCAN_DATA,
  output logic                      oEVENT_VALID,
  output logic [9:0]                oEVENT_DATA,
  input  logic                      iEVENT_ACK,
  output logic [P_FIFO_DEPTH_N:0]   oEVENT_COUNT,
  output logic                      oOVERFLOW,
  input  logic                      iOVERFLOW_CLEAR
);
  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;
  localparam int CW = P_FIFO_DEPTH_N + 1;
  localparam logic [P_FIFO_DEPTH_N-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(P_FIFO_DEPTH);
  state_t state_q, state_d;
  logic [2:0] pause_cnt_q, pause_cnt_d;
  logic [P_FIFO_DEPTH_N-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic [9:0] mem_q [P_FIFO_DEPTH];
  logic [9:0] event_d;
  logic emit, push, pop, full, empty, is_filter, is_prefix;
  always_comb begin
    is_filter = iSCAN_DATA inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    is_prefix = iSCAN_DATA inside {8'hE0, 8'hE1, 8'hF0};
    state_d = state_q;
    pause_cnt_d = pause_cnt_q;
    emit = 1'b0;
    event_d = {2'b00, iSCAN_DATA};
    if (iSCAN_REQ) begin
      case (state_q)
        ST_IDLE: begin
          state_d = (iSCAN_DATA == 8'hE0) ? ST_EXT :
                    (iSCAN_DATA == 8'hF0) ? ST_BRK :
                    (iSCAN_DATA == 8'hE1) ? ST_PAUSE : ST_IDLE;
          pause_cnt_d = (iSCAN_DATA == 8'hE1) ? 3'd7 : pause_cnt_q;
          emit = !is_filter && !is_prefix;
        end
        ST_EXT: begin
          state_d = (iSCAN_DATA == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
          emit = !is_filter && !is_prefix;
          event_d = {2'b10, iSCAN_DATA};
        end
        ST_BRK, ST_EXT_BRK: begin
          state_d = ST_IDLE;
          emit = !is_filter && !is_prefix;
          event_d = {state_q == ST_EXT_BRK, 1'b1, iSCAN_DATA};
        end
        ST_PAUSE: begin
          // Pause is a fixed 8-byte sequence; the body bytes are not inspected.
          pause_cnt_d = pause_cnt_q - 3'd1;
          state_d = (pause_cnt_q == 3'd1) ? ST_IDLE : ST_PAUSE;
          emit = pause_cnt_q == 3'd1;
          event_d = 10'h2E1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_comb begin
    empty = count_q == '0;
    full = count_q == CNT_FULL;
    pop = iEVENT_ACK && !empty;
    // A pop on the same edge frees the slot a full FIFO needs for the write.
    push = emit && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
    overflow_d = (emit && full && !pop) ? 1'b1 : iOVERFLOW_CLEAR ? 1'b0 : overflow_q;
  end
  always_ff @(posedge iCLOCK) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      pause_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_cnt_q <= pause_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge iCLOCK) begin
    if (inRESET && push) mem_q[wr_ptr_q] <= event_d;
  end
  assign oEVENT_VALID = !empty;
  assign oEVENT_DATA = empty ? '0 : mem_q[rd_ptr_q];
  assign oEVENT_COUNT = count_q;
  assign oOVERFLOW = overflow_q;
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the raw byte stream from the PS/2 receive stage: one-cycle request plus an 8-bit Set-2 scancode.
- Folds the E0 (extended), F0 (break) and E1 (Pause) prefixes into single key events.
- Buffers events in a first-word-fall-through FIFO that the keyboard device register block pops through a valid/ack handshake.

Parameters:
- P_FIFO_DEPTH, 16, event FIFO entries; must be a power of 2.
- P_FIFO_DEPTH_N, 4, log2(P_FIFO_DEPTH); pointer width.

Ports:
- iCLOCK  in  1  system clock, 50 MHz.
- inRESET  in  1  synchronous active-low reset, sampled on rising iCLOCK.
- iSCAN_REQ  in  1  one-cycle pulse: byte valid from receive stage.
- iSCAN_DATA  in  8  scancode byte; valid only while iSCAN_REQ=1.
- oEVENT_VALID  out  1  FIFO non-empty; head event presented.
- oEVENT_DATA  out  10  [9]=extended, [8]=break, [7:0]=code; 0 when empty.
- iEVENT_ACK  in  1  pop head when oEVENT_VALID=1.
- oEVENT_COUNT  out  P_FIFO_DEPTH_N+1  current FIFO occupancy.
- oOVERFLOW  out  1  sticky: an event was lost because the FIFO was full.
- iOVERFLOW_CLEAR  in  1  clears oOVERFLOW.

Behaviour:
- Reset (inRESET=0 at an edge): state=IDLE, pause counter=0, FIFO pointers and count=0, oOVERFLOW=0. Outputs are then oEVENT_VALID=0, oEVENT_DATA=0, oEVENT_COUNT=0. Reset overrides all other inputs. Reset mid-sequence discards any partial prefix.
- Decoder FSM advances only on edges with iSCAN_REQ=1:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE, counter=7.
    - Filter byte (00, AA, EE, FA, FC, FD, FE, FF) -> dropped, stay IDLE.
    - Any other byte -> emit {0,0,byte}, stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - Filter byte, E0 or E1 -> IDLE, no event.
    - Any other byte -> emit {1,0,byte}, go IDLE.
  - BRK:
    - Filter byte, E0, E1 or F0 -> IDLE, no event.
    - Any other byte -> emit {0,1,byte}, go IDLE.
  - EXT_BRK:
    - Filter byte, E0, E1 or F0 -> IDLE, no event.
    - Any other byte -> emit {1,1,byte}, go IDLE.
  - PAUSE:
    - Each byte decrements the counter; contents are not checked.
    - On the byte that takes the counter 1->0: emit {1,0,8'hE1}, go IDLE.
- Emit writes the FIFO on the same edge the byte is sampled. oEVENT_VALID rises after that edge (1-cycle latency, empty FIFO).
- FIFO:
  - Head is combinationally presented on oEVENT_DATA.
  - Pop = iEVENT_ACK & oEVENT_VALID. Ack while empty is ignored.
  - Full and write without pop: event dropped, oOVERFLOW<=1, count stays P_FIFO_DEPTH.
  - Full with simultaneous write and pop: both performed, no overflow, count unchanged.
  - Empty with simultaneous write and ack: ack ignored, count becomes 1.
  - Pointers wrap modulo P_FIFO_DEPTH. Count is P_FIFO_DEPTH_N+1 bits and reaches P_FIFO_DEPTH exactly.
- Overflow flag: iOVERFLOW_CLEAR clears oOVERFLOW on the next edge. If a new overflow occurs on the same edge, set wins.
- No timeout. A prefix waits indefinitely for its next byte.
- All state registers update on posedge iCLOCK only.

Test Plan:
- Make code: reset, then REQ with 1C -> next cycle VALID=1, DATA=0x01C, COUNT=1; ACK -> VALID=0, DATA=0x000.
- Prefix folding: F0,1C then E0,75 then E0,F0,75 -> exactly three events, popped in order 0x11C, 0x275, 0x375.
- Pause: E1,14,77,E1,F0,14,F0,77 -> exactly one event 0x2E1, and only after the 8th byte.
- Filtering and abort: FA, AA, then E0,FE, then 1C -> one event 0x01C, FSM back in IDLE.
- Overflow and wrap:
  - 17 makes 0x01..0x11 with no ACK -> COUNT=16, OVERFLOW=1, heads pop 0x001..0x010.
  - With FIFO full, REQ 0x20 with simultaneous ACK -> OVERFLOW unchanged, COUNT=16.
  - Assert iOVERFLOW_CLEAR -> OVERFLOW=0.
  - After draining, 20 more write/pop pairs confirm pointer wrap.
- Reset mid-operation: 3 events queued, E0 received, inRESET=0 for one cycle -> VALID=0, COUNT=0; then 1C -> 0x01C (not 0x21C).
